watchdog_reset: RTL and testbench

- Software-kicked watchdog that requests a system reset when the CPU stops servicing it.
- Drives an active-low reset-request pulse into the power-on reset/clock block's external reset input (reset_ext).
- It is therefore the initiator of the reset that block consumes.
- Clocked on the same domain as the core. Its own reset comes from power-on only and must never be wired from its own reset_req_n.

---
 rtl/watchdog_reset_pkg.sv | 15 +
 rtl/watchdog_reset_pulse_gen.sv | 35 +++
 rtl/watchdog_reset.sv | 124 ++++++++++++
 tb/tb_watchdog_reset.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/watchdog_reset_pkg.sv
// Shared definitions for the watchdog reset block: state encoding and default sizing.
package watchdog_reset_pkg;

    typedef enum logic [1:0] {
        WDT_DISARMED = 2'd0,
        WDT_RUN      = 2'd1,
        WDT_WARN     = 2'd2,
        WDT_FIRE     = 2'd3
    } wdt_state_e;

    localparam int WDT_CNT_WIDTH    = 24;
    localparam int WDT_WARN_CYCLES  = 256;
    localparam int WDT_PULSE_CYCLES = 16;

endpackage

// File: rtl/watchdog_reset_pulse_gen.sv
// Loadable down-counter that times the reset-request pulse; done strobes on the
// last low cycle so the owner can leave FIRE exactly PULSE_CYCLES after load.
module wdt_pulse_gen
    import watchdog_reset_pkg::*;
#(
    parameter int PULSE_CYCLES = WDT_PULSE_CYCLES
) (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    output logic done
);

    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam logic [PW-1:0] PW_ONE  = PW'(1'b1);
    localparam logic [PW-1:0] PW_LOAD = PW'(PULSE_CYCLES);

    logic [PW-1:0] cnt_r;

    // Pulse length counter: load, then count down to zero and hold.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r <= {PW{1'b0}};
        end else if (load) begin
            cnt_r <= PW_LOAD;
        end else if (cnt_r != {PW{1'b0}}) begin
            cnt_r <= cnt_r - PW_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == PW_ONE);

endmodule

// File: rtl/watchdog_reset.sv
// Software-kicked watchdog driving an active-low reset-request pulse.
// Optional macro WDT_LOCK_EN: once armed, disarm and re-arm with a new timeout are ignored.
module watchdog_reset
    import watchdog_reset_pkg::*;
#(
    parameter int CNT_WIDTH    = WDT_CNT_WIDTH,
    parameter int WARN_CYCLES  = WDT_WARN_CYCLES,
    parameter int PULSE_CYCLES = WDT_PULSE_CYCLES
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 cfg_we,
    input  logic                 cfg_arm,
    input  logic [CNT_WIDTH-1:0] cfg_timeout,
    input  logic                 kick,
    input  logic                 clr_flag,
    output logic                 reset_req_n,
    output logic                 warn_irq,
    output logic                 running,
    output logic                 expired_flag,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1'b1);
    localparam logic [CNT_WIDTH-1:0] WARN_LVL = CNT_WIDTH'(WARN_CYCLES);

    wdt_state_e           state_r, state_s;
    logic [CNT_WIDTH-1:0] timeout_r, timeout_s, count_s;
    logic                 arm_ok_s, cfg_act_s, pulse_load_s, pulse_done_s, flag_set_s;

    assign arm_ok_s = cfg_we & cfg_arm & (cfg_timeout != CNT_ZERO);

    // A config write while counting either reloads or disarms; a zero-timeout arm is a no-op.
`ifdef WDT_LOCK_EN
    assign cfg_act_s = cfg_we & cfg_arm & (cfg_timeout == timeout_r);
`else
    assign cfg_act_s = cfg_we & (~cfg_arm | (cfg_timeout != CNT_ZERO));
`endif

    wdt_pulse_gen #(
        .PULSE_CYCLES (PULSE_CYCLES)
    ) u_pulse (
        .clk    (clk),
        .resetn (resetn),
        .load   (pulse_load_s),
        .done   (pulse_done_s)
    );

    // Next-state, counter and timeout-register logic.
    always_comb begin
        state_s      = state_r;
        count_s      = count;
        timeout_s    = timeout_r;
        pulse_load_s = 1'b0;
        flag_set_s   = 1'b0;
        case (state_r)
            WDT_DISARMED: begin
                if (arm_ok_s) begin
                    timeout_s = cfg_timeout;
                    count_s   = cfg_timeout;
                    state_s   = WDT_RUN;
                end else begin
                    state_s = WDT_DISARMED;
                end
            end
            WDT_RUN, WDT_WARN: begin
                if (cfg_act_s) begin
                    if (cfg_arm) begin
                        timeout_s = cfg_timeout;
                        count_s   = cfg_timeout;
                        state_s   = WDT_RUN;
                    end else begin
                        state_s = WDT_DISARMED;
                    end
                end else if (kick) begin
                    count_s = timeout_r;
                    state_s = WDT_RUN;
                end else if ((state_r == WDT_WARN) && (count <= CNT_ONE)) begin
                    // <= rather than == so a timeout of 1 (reaching WARN at 0) still fires
                    count_s      = CNT_ZERO;
                    state_s      = WDT_FIRE;
                    pulse_load_s = 1'b1;
                end else begin
                    count_s = (count != CNT_ZERO) ? (count - CNT_ONE) : CNT_ZERO;
                    state_s = (count_s <= WARN_LVL) ? WDT_WARN : WDT_RUN;
                end
            end
            WDT_FIRE: begin
                if (pulse_done_s) begin
                    state_s    = WDT_DISARMED;
                    flag_set_s = 1'b1;
                end else begin
                    state_s = WDT_FIRE;
                end
            end
            default: begin
                state_s = WDT_DISARMED;
            end
        endcase
    end

    // State and registered outputs, all decoded from the next state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= WDT_DISARMED;
            count        <= CNT_ZERO;
            timeout_r    <= CNT_ZERO;
            reset_req_n  <= 1'b1;
            warn_irq     <= 1'b0;
            running      <= 1'b0;
            expired_flag <= 1'b0;
        end else begin
            state_r      <= state_s;
            count        <= count_s;
            timeout_r    <= timeout_s;
            reset_req_n  <= (state_s != WDT_FIRE);
            warn_irq     <= (state_s == WDT_WARN);
            running      <= (state_s == WDT_RUN) || (state_s == WDT_WARN);
            expired_flag <= flag_set_s | (expired_flag & ~clr_flag);
        end
    end

endmodule

// File: tb/tb_watchdog_reset.sv
// Self-checking bench for watchdog_reset: directed scenarios plus random stimulus
// against a behavioural model. Honours WDT_LOCK_EN like the design.
module tb_watchdog_reset;

    localparam int CW    = 24;
    localparam int WARN  = 256;
    localparam int PULSE = 16;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          cfg_we = 1'b0, cfg_arm = 1'b0, kick = 1'b0, clr_flag = 1'b0;
    logic [CW-1:0] cfg_timeout = '0;
    logic          reset_req_n, warn_irq, running, expired_flag;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_pass   = 0;

    // behavioural model
    bit m_armed, m_fresh, m_firing, m_flag;
    int m_cnt, m_tmo, m_pulse;

    watchdog_reset dut (
        .clk          (clk),
        .resetn       (resetn),
        .cfg_we       (cfg_we),
        .cfg_arm      (cfg_arm),
        .cfg_timeout  (cfg_timeout),
        .kick         (kick),
        .clr_flag     (clr_flag),
        .reset_req_n  (reset_req_n),
        .warn_irq     (warn_irq),
        .running      (running),
        .expired_flag (expired_flag),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_armed = 0; m_fresh = 0; m_firing = 0; m_flag = 0;
        m_cnt = 0; m_tmo = 0; m_pulse = 0;
    endtask

    // One clock of the watchdog rules, using the inputs present at the edge.
    task automatic model_step();
        bit set_now;
        bit hit;
        set_now = 0;
        if (m_firing) begin
            m_pulse--;
            if (m_pulse == 0) begin
                m_firing = 0;
                set_now  = 1;
            end
        end else if (m_armed) begin
`ifdef WDT_LOCK_EN
            hit = cfg_we && cfg_arm && (int'(cfg_timeout) == m_tmo);
`else
            hit = cfg_we && (!cfg_arm || cfg_timeout != 0);
`endif
            if (hit) begin
                if (cfg_arm) begin
                    m_tmo = int'(cfg_timeout); m_cnt = m_tmo; m_fresh = 1;
                end else begin
                    m_armed = 0;
                end
            end else if (kick) begin
                m_cnt = m_tmo; m_fresh = 1;
            end else if (!m_fresh && m_cnt <= 1) begin
                m_armed = 0; m_firing = 1; m_pulse = PULSE; m_cnt = 0;
            end else begin
                if (m_cnt > 0) m_cnt--;
                m_fresh = 0;
            end
        end else if (cfg_we && cfg_arm && cfg_timeout != 0) begin
            m_armed = 1; m_tmo = int'(cfg_timeout); m_cnt = m_tmo; m_fresh = 1;
        end
        if (set_now) m_flag = 1;
        else if (clr_flag) m_flag = 0;
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".reset_req_n"}, 32'(reset_req_n), 32'(!m_firing));
        check_val({tag, ".warn_irq"}, 32'(warn_irq), 32'(m_armed && !m_fresh && m_cnt <= WARN));
        check_val({tag, ".running"}, 32'(running), 32'(m_armed));
        check_val({tag, ".expired_flag"}, 32'(expired_flag), 32'(m_flag));
        check_val({tag, ".count"}, 32'(count), 32'(m_cnt));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_outputs(tag);
        cfg_we = 0; cfg_arm = 0; kick = 0; clr_flag = 0;
    endtask

    task automatic arm(input int t, input string tag);
        cfg_we = 1; cfg_arm = 1; cfg_timeout = CW'(t);
        step(tag);
    endtask

    task automatic disarm(input string tag);
        cfg_we = 1; cfg_arm = 0;
        step(tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        int warn_at, low_start, low_len, found, bad;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        #2 resetn = 1;

        // no kicks: warn at 256, pulse of 16 starting at the 1000th edge after arm
        arm(1000, "arm1000");
        warn_at = -1; low_start = -1; low_len = 0;
        for (int k = 1; k <= 1040; k++) begin
            step("expire");
            if (warn_irq && warn_at < 0) warn_at = k;
            if (!reset_req_n) begin
                if (low_start < 0) low_start = k;
                low_len++;
            end
        end
        check_val("warn_rise_cycle", warn_at, 744);
        check_val("fire_start_cycle", low_start, 1000);
        check_val("pulse_len", low_len, PULSE);
        check_val("expired_after_fire", 32'(expired_flag), 1);
        clr_flag = 1; step("clr");
        check_val("flag_cleared", 32'(expired_flag), 0);

        // regular kicks keep it quiet
        arm(1000, "arm_kick");
        bad = 0;
        for (int k = 1; k <= 10000; k++) begin
            if (k % 500 == 0) kick = 1;
            step("kick500");
            if (warn_irq || !reset_req_n) bad++;
        end
        check_val("kick500_quiet", bad, 0);
        disarm("disarm1");

        // kick on the cycle count==1
        arm(1000, "arm_k1");
        found = 0;
        for (int k = 0; k < 1100 && found == 0; k++) begin
            if (m_cnt == 1 && m_armed) begin
                check_val("warn_before_k1", 32'(warn_irq), 1);
                kick = 1;
                step("kick_at_one");
                check_val("k1_count_reload", 32'(count), 1000);
                check_val("k1_warn_drop", 32'(warn_irq), 0);
                check_val("k1_no_fire", 32'(reset_req_n), 1);
                found = 1;
            end else begin
                step("to_one");
            end
        end
        check_val("kick_at_one_reached", found, 1);
        disarm("disarm2");

        // short timeout enters WARN immediately, fires after 100
        arm(100, "arm100");
        check_val("arm100_no_warn_yet", 32'(warn_irq), 0);
        step("arm100_next");
        check_val("arm100_warn", 32'(warn_irq), 1);
        low_start = -1;
        for (int k = 2; k <= 130; k++) begin
            step("fire100");
            if (!reset_req_n && low_start < 0) low_start = k;
        end
        check_val("fire100_start", low_start, 100);
        arm(0, "arm_zero");
        check_val("arm_zero_running", 32'(running), 0);

        // reset in the middle of FIRE
        arm(20, "arm20");
        found = 0;
        for (int k = 0; k < 60 && found == 0; k++) begin
            step("to_fire");
            if (!reset_req_n) found = 1;
        end
        check_val("reached_fire", found, 1);
        repeat (4) step("in_fire");
        #1 resetn = 0;
        #1;
        model_reset();
        check_val("midfire_req_n", 32'(reset_req_n), 1);
        check_outputs("midfire_reset");
        #2 resetn = 1;

        // kick and cfg_we cannot shorten or cancel the pulse
        arm(20, "arm20b");
        low_len = 0;
        for (int k = 0; k < 80; k++) begin
            if (m_firing) begin
                kick = 1; cfg_we = 1; cfg_arm = k[0]; cfg_timeout = CW'(500);
            end
            step("fire_ignore");
            if (!reset_req_n) low_len++;
        end
        check_val("pulse_len_ignore", low_len, PULSE);

        // disarm attempt after arming
        arm(1000, "arm_lock");
        disarm("lock_disarm");
        low_start = -1;
        for (int k = 2; k <= 1010; k++) begin
            step("lock_run");
            if (!reset_req_n && low_start < 0) low_start = k;
        end
`ifdef WDT_LOCK_EN
        check_val("lock_fire_start", low_start, 1000);
`else
        check_val("unlock_no_fire", low_start, -1);
`endif
        repeat (20) step("settle");

        // random traffic against the model
        for (int k = 0; k < 4000; k++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                cfg_we = 1; cfg_arm = 1; cfg_timeout = CW'($urandom_range(0, 300));
            end else if (r < 4) begin
                cfg_we = 1; cfg_arm = 0;
            end else if (r < 9) begin
                kick = 1;
            end
            if ($urandom_range(0, 49) == 0) clr_flag = 1;
            step("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
